// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the mul/div unit.
//
// Contents:
//   DIV_WIDTH    default divisor/quotient/remainder width (dividend is 2x)
//   div_state_t  divider FSM states (IDLE, RUN, DONE)
//   DIV_CNT_W    iteration counter width for the default width
//   div_cnt_w()  counter width helper for any width (minimum 1 bit)
package md_pkg;

    localparam int unsigned DIV_WIDTH = 64;

    // Explicit 2-bit encoding keeps the state register readable in
    // existing waveform/decode scripts.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    function automatic int unsigned div_cnt_w(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : md_pkg

// File: rtl/div_128by64_seq_if.sv
// div_128by64_seq_if: request/result bundle of the iterative divider.
//
// Signal names are from the divider's point of view (_i into the divider,
// _o out of it).
//   start_i      request valid (accepted when start_i && ready_o)
//   ready_o      divider idle and able to accept
//   N_i          2*WIDTH-bit dividend
//   D_i          WIDTH-bit divisor
//   valid_o      result valid, held until consumed
//   out_ready_i  consumer takes the result when valid_o && out_ready_i
//   Q_o / R_o    quotient / remainder
//   dz_o / ovf_o divide-by-zero / quotient-overflow flags
//
// Modports: slave = divider side, master = requester/consumer side.
interface div_128by64_seq_if #(
    parameter int unsigned WIDTH = md_pkg::DIV_WIDTH
);
    logic                   start_i;
    logic                   ready_o;
    logic [2*WIDTH-1:0]     N_i;
    logic [WIDTH-1:0]       D_i;
    logic                   valid_o;
    logic                   out_ready_i;
    logic [WIDTH-1:0]       Q_o;
    logic [WIDTH-1:0]       R_o;
    logic                   dz_o;
    logic                   ovf_o;

    modport slave (
        input  start_i, N_i, D_i, out_ready_i,
        output ready_o, valid_o, Q_o, R_o, dz_o, ovf_o
    );

    modport master (
        output start_i, N_i, D_i, out_ready_i,
        input  ready_o, valid_o, Q_o, R_o, dz_o, ovf_o
    );

endinterface : div_128by64_seq_if

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division step.
//
// Ports:
//   rem_i   partial remainder (WIDTH+1 bits, always < d_i on entry)
//   bit_i   next dividend bit shifted into the remainder
//   d_i     divisor
//   rem_o   new partial remainder (< d_i)
//   qbit_o  quotient bit produced by this step
//
// Kept separate so two instances can be chained for a 2-bit/cycle unroll.
module div_step #(
    parameter int unsigned WIDTH = md_pkg::DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] d_ext;
    // rem_i < d_i guarantees the top bit is clear; it only widens the register.
    logic           unused_rem_msb;

    assign unused_rem_msb = rem_i[WIDTH];
    assign trial          = {rem_i[WIDTH-1:0], bit_i};
    assign d_ext          = {1'b0, d_i};

    // The trial value can reach 2*d-1, so the compare must be WIDTH+1 bits wide.
    always_comb begin
        if (trial >= d_ext) begin
            rem_o  = trial - d_ext;
            qbit_o = 1'b1;
        end else begin
            rem_o  = trial;
            qbit_o = 1'b0;
        end
    end

endmodule : div_step

// File: rtl/div_128by64_seq.sv
// div_128by64_seq: iterative unsigned divider, 2*WIDTH / WIDTH bits.
//
// Radix-2 restoring division, one quotient bit per clock. Divide-by-zero
// and quotient overflow are detected at accept time and reported without
// iterating.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-low reset
//   bus    div_128by64_seq_if.slave (request and result handshakes)
//
// Timing (accept edge = edge 0): the result is visible to the consumer at
// edge WIDTH+1 for a normal divide and at edge 1 for dz/ovf. ready_o is
// low in RUN and DONE, so back-to-back operations are WIDTH+2 cycles apart.
module div_128by64_seq
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    div_128by64_seq_if.slave         bus
);

    localparam int unsigned CNT_W = div_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   qsh_q, qsh_d;
    logic [WIDTH-1:0]   dreg_q, dreg_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH:0]     step_rem;
    logic               step_qbit;
    logic [WIDTH-1:0]   qsh_shifted;
    logic [WIDTH-1:0]   n_hi;
    logic [WIDTH-1:0]   n_lo;

    assign n_hi = bus.N_i[2*WIDTH-1:WIDTH];
    assign n_lo = bus.N_i[WIDTH-1:0];

    // qsh holds the not-yet-consumed dividend bits in its top and the
    // quotient bits built so far in its bottom; one shift serves both.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (qsh_q[WIDTH-1]),
        .d_i    (dreg_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    assign qsh_shifted = {qsh_q[WIDTH-2:0], step_qbit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        qsh_d   = qsh_q;
        dreg_d  = dreg_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (bus.D_i == '0) begin
                        // dz wins over ovf: an upper half >= 0 would also trip ovf.
                        state_d = DONE;
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        q_d     = '1;
                        r_d     = n_lo;
                    end else if (n_hi >= bus.D_i) begin
                        // Quotient would not fit in WIDTH bits.
                        state_d = DONE;
                        dz_d    = 1'b0;
                        ovf_d   = 1'b1;
                        q_d     = '1;
                        r_d     = '0;
                    end else begin
                        state_d = RUN;
                        rem_d   = {1'b0, n_hi};
                        qsh_d   = n_lo;
                        dreg_d  = bus.D_i;
                        cnt_d   = '0;
                    end
                end
            end

            RUN: begin
                rem_d = step_rem;
                qsh_d = qsh_shifted;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Result registers are separate from the working
                    // registers so the last result stays visible while idle.
                    state_d = DONE;
                    q_d     = qsh_shifted;
                    r_d     = step_rem[WIDTH-1:0];
                    dz_d    = 1'b0;
                    ovf_d   = 1'b0;
                end
            end

            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            qsh_q   <= '0;
            dreg_q  <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            qsh_q   <= qsh_d;
            dreg_q  <= dreg_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.ready_o = (state_q == IDLE);
    assign bus.valid_o = (state_q == DONE);
    assign bus.Q_o     = q_q;
    assign bus.R_o     = r_q;
    assign bus.dz_o    = dz_q;
    assign bus.ovf_o   = ovf_q;

endmodule : div_128by64_seq
